// File: rtl/my_adc_axil_bank.sv
// AXI4-Lite register bank fronting a multi-channel ADC sample capture block.
// Each channel latches strobed samples into DATA_k, tracks VALID/OVF, and
// can raise a level interrupt. Reads of DATA_k consume the sample.
`timescale 1ns/1ps
module my_adc_axil_bank #(
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned SAMPLE_WIDTH       = 12,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [31:0]                    S_AXI_WDATA,
  input  logic [3:0]                     S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [31:0]                    S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  input  logic [NUM_CH-1:0]              smp_valid,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] smp_data,
  output logic                           irq
);

  localparam int unsigned AW        = C_S_AXI_ADDR_WIDTH;
  localparam logic [7:0]  CH_MASK   = 8'((1 << NUM_CH) - 1);
  localparam logic [31:0] CTRL_MASK = {16'h0000, CH_MASK, 8'h03};

  logic                    arm_q;
  logic                    awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]             rdata_q;
  logic [31:0]             ctrl_q, ctrl_d, scratch_q, scratch_d;
  logic [NUM_CH-1:0]       valid_q, valid_d, ovf_q, ovf_d;
  logic [SAMPLE_WIDTH-1:0] data_q [NUM_CH];
  logic                    irq_q;

  logic              wr_en, rd_en;
  int unsigned       wr_idx, rd_idx;
  logic [31:0]       rd_mux;
  logic [NUM_CH-1:0] rd_clr, cap, ie;
  logic              sgn;
  logic              unused_addr_bits;

  // Handshake completes on the edge where the registered READY is seen with VALID.
  assign wr_en  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en  = arready_q & S_AXI_ARVALID;
  assign wr_idx = 32'(S_AXI_AWADDR[AW-1:2]);
  assign rd_idx = 32'(S_AXI_ARADDR[AW-1:2]);
  assign sgn    = ctrl_q[1];
  assign ie     = ctrl_q[8 +: NUM_CH];
  assign cap    = ctrl_q[0] ? smp_valid : '0;

  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;

  // Read mux and per-channel read-consume strobes; SIGNED applied here, at read time.
  always_comb begin
    rd_mux = '0;
    rd_clr = '0;
    case (rd_idx)
      0:       rd_mux = ctrl_q;
      1:       rd_mux = {16'h0000, 8'(ovf_q), 8'(valid_q)};
      2:       rd_mux = scratch_q;
      default: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (rd_idx == 4 + k) begin
            rd_clr[k] = rd_en;
            if (sgn) begin
              rd_mux = {{(32-SAMPLE_WIDTH){data_q[k][SAMPLE_WIDTH-1]}}, data_q[k]};
            end else begin
              rd_mux = 32'(data_q[k]);
            end
          end
        end
      end
    endcase
  end

  // Register writes, W1C of OVF, then capture events (capture beats read-clear and W1C).
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) begin
          if (wr_idx == 0) ctrl_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
          if (wr_idx == 2) scratch_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
        end
      end
      if (wr_idx == 1 && S_AXI_WSTRB[1]) ovf_d = ovf_q & ~S_AXI_WDATA[8 +: NUM_CH];
    end
    ctrl_d = ctrl_d & CTRL_MASK;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (rd_clr[k]) valid_d[k] = 1'b0;
      if (cap[k]) begin
        valid_d[k] = 1'b1;
        // A sample consumed on this same edge is not lost, so no overflow.
        if (valid_q[k] && !rd_clr[k]) ovf_d[k] = 1'b1;
      end
    end
  end

  // AXI handshake state, read data register and registered interrupt.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arm_q     <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      // arm_q holds off any READY until the first edge after reset has passed.
      arm_q     <= 1'b1;
      awready_q <= arm_q & ~awready_q & ~bvalid_q & S_AXI_AWVALID & S_AXI_WVALID;
      arready_q <= arm_q & ~arready_q & ~rvalid_q & S_AXI_ARVALID;
      if (wr_en) begin
        bvalid_q <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
      irq_q <= |(valid_q & ie);
    end
  end

  // Control, scratch and channel status registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      valid_q   <= '0;
      ovf_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  // Per-channel sample holding registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int unsigned k = 0; k < NUM_CH; k++) data_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (cap[k]) data_q[k] <= smp_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_my_adc_axil_bank.sv
// Directed bench for my_adc_axil_bank: register table plus capture corner cases.
`timescale 1ns/1ps
module tb_my_adc_axil_bank;

  localparam int NCH = 4;
  localparam int SW  = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [5:0]    awaddr = '0, araddr = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic          arvalid = 1'b0, rready = 1'b1;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NCH-1:0]    smp_valid = '0;
  logic [NCH*SW-1:0] smp_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  my_adc_axil_bank #(
    .NUM_CH(NCH),
    .SAMPLE_WIDTH(SW),
    .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .smp_valid(smp_valid),
    .smp_data(smp_data),
    .irq(irq)
  );

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no handshake, expected one within 50 cycles", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write; hs_v/hs_d are strobed on the handshake edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [NCH-1:0] hs_v, input logic [NCH*SW-1:0] hs_d);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!awready && n < 50) begin tick(); n++; end
    if (!awready) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timeout("aw_ready");
      return;
    end
    smp_valid = hs_v; smp_data = hs_d;
    tick();
    smp_valid = '0; awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    if (!bvalid) begin
      timeout("b_valid");
      return;
    end
    check("bresp", 64'(bresp), 64'd0);
    tick();
  endtask

  task automatic rd(input logic [5:0] a, input logic [NCH-1:0] hs_v,
                    input logic [NCH*SW-1:0] hs_d, output logic [31:0] d);
    int n = 0;
    d = 'x;
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    if (!arready) begin
      arvalid = 1'b0;
      timeout("ar_ready");
      return;
    end
    smp_valid = hs_v; smp_data = hs_d;
    tick();
    smp_valid = '0; arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (!rvalid) begin
      timeout("r_valid");
      return;
    end
    d = rdata;
    check("rresp", 64'(rresp), 64'd0);
    tick();
  endtask

  task automatic w(input logic [5:0] a, input logic [31:0] d);
    wr(a, d, 4'hF, '0, '0);
  endtask

  task automatic rchk(input string name, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, '0, '0, d);
    check(name, 64'(d), 64'(exp));
  endtask

  task automatic strobe(input logic [NCH-1:0] v, input logic [NCH*SW-1:0] d);
    smp_valid = v; smp_data = d;
    tick();
    smp_valid = '0;
  endtask

  function automatic logic [63:0] outs();
    return 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, irq});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    vecs[0]  = '{1'b1, 6'h00, 32'h00000001, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 6'h04, 32'h00000002, 4'hF, 32'h0};
    vecs[2]  = '{1'b1, 6'h08, 32'h00000003, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 6'h0C, 32'h00000004, 4'hF, 32'h0};
    vecs[4]  = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h00000001};
    vecs[5]  = '{1'b0, 6'h04, 32'h0, 4'h0, 32'h00000000};
    vecs[6]  = '{1'b0, 6'h08, 32'h0, 4'h0, 32'h00000003};
    vecs[7]  = '{1'b0, 6'h0C, 32'h0, 4'h0, 32'h00000000};
    vecs[8]  = '{1'b1, 6'h08, 32'hAABBCCDD, 4'h5, 32'h0};
    vecs[9]  = '{1'b0, 6'h08, 32'h0, 4'h0, 32'h00BB00DD};
    vecs[10] = '{1'b1, 6'h00, 32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h00000F03};
    vecs[12] = '{1'b0, 6'h3C, 32'h0, 4'h0, 32'h00000000};
    vecs[13] = '{1'b0, 6'h20, 32'h0, 4'h0, 32'h00000000};
    vecs[14] = '{1'b0, 6'h10, 32'h0, 4'h0, 32'h00000000};
    vecs[15] = '{1'b1, 6'h0A, 32'h12345678, 4'hF, 32'h0};
    vecs[16] = '{1'b0, 6'h09, 32'h0, 4'h0, 32'h12345678};
    vecs[17] = '{1'b1, 6'h00, 32'h00000000, 4'hF, 32'h0};
    vecs[18] = '{1'b0, 6'h00, 32'h0, 4'h0, 32'h00000000};

    // Reset state, with a write already pending across release.
    awaddr = 6'h0C; wdata = 32'h5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    check("no_ready_first_edge", 64'({awready, wready}), 64'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) tick();
    if (bvalid) tick();

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].data, vecs[i].strb, '0, '0);
      end else begin
        rd(vecs[i].addr, '0, '0, d);
        check($sformatf("vec%0d", i), 64'(d), 64'(vecs[i].exp));
      end
    end

    // EN=0 drops strobes.
    strobe(4'b0001, 48'h000_000_000_123);
    rchk("en0_status", 6'h04, 32'h0);
    rchk("en0_data0", 6'h10, 32'h0);

    // Capture, interrupt and consume.
    w(6'h00, 32'h00000101);
    strobe(4'b0001, 48'h000_000_000_ABC);
    check("irq_registered", 64'(irq), 64'd0);
    tick();
    check("irq_set", 64'(irq), 64'd1);
    rchk("status_valid0", 6'h04, 32'h00000001);
    rchk("data0", 6'h10, 32'h00000ABC);
    check("irq_clear", 64'(irq), 64'd0);
    rchk("status_after_read", 6'h04, 32'h0);

    // Signed formatting applied at read time.
    w(6'h00, 32'h00000003);
    strobe(4'b0010, 48'h000_000_800_000);
    rchk("data1_signed", 6'h14, 32'hFFFFF800);
    w(6'h00, 32'h00000001);
    rchk("data1_unsigned", 6'h14, 32'h00000800);

    // Overflow and W1C.
    strobe(4'b0100, 48'h000_111_000_000);
    strobe(4'b0100, 48'h000_222_000_000);
    rchk("ovf2_set", 6'h04, 32'h00000404);
    wr(6'h04, 32'h00000400, 4'h1, '0, '0);
    rchk("w1c_needs_lane1", 6'h04, 32'h00000404);
    w(6'h04, 32'h00000400);
    rchk("ovf2_cleared", 6'h04, 32'h00000004);
    rchk("data2", 6'h18, 32'h00000222);
    rchk("status_clean2", 6'h04, 32'h0);

    // Capture on the read-accept edge wins.
    strobe(4'b1000, 48'h044_000_000_000);
    rd(6'h1C, 4'b1000, 48'h055_000_000_000, d);
    check("race_old_data", 64'(d), 64'h044);
    rchk("race_status", 6'h04, 32'h00000008);
    rchk("race_new_data", 6'h1C, 32'h00000055);
    rchk("status_clean3", 6'h04, 32'h0);

    // W1C coinciding with an overflow keeps OVF set.
    strobe(4'b0001, 48'h000_000_000_001);
    strobe(4'b0001, 48'h000_000_000_002);
    rchk("ovf0_set", 6'h04, 32'h00000101);
    wr(6'h04, 32'h00000100, 4'hF, 4'b0001, 48'h000_000_000_003);
    rchk("ovf0_w1c_race", 6'h04, 32'h00000101);
    w(6'h04, 32'h00000100);
    rchk("ovf0_cleared", 6'h04, 32'h00000001);
    rchk("data0_latest", 6'h10, 32'h00000003);

    // All channels in one cycle.
    strobe(4'b1111, 48'h444_333_222_111);
    rchk("all_valid", 6'h04, 32'h0000000F);
    for (int k = 0; k < NCH; k++) begin
      logic [31:0] e;
      e = 32'h111 * (k + 1);
      rchk($sformatf("all_data%0d", k), 6'(6'h10 + 4 * k), e);
    end

    // Write response back-pressure.
    bready = 1'b0;
    awaddr = 6'h08; wdata = 32'h0000CAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 50 && !awready; n++) tick();
    tick();
    wdata = 32'h0000BEEF;
    for (int i = 0; i < 10; i++) begin
      check("b_stall_valid", 64'({bvalid, bresp}), 64'h4);
      check("b_stall_noaccept", 64'(awready), 64'd0);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    check("b_release", 64'(bvalid), 64'd0);

    // Read data back-pressure.
    rready = 1'b0;
    araddr = 6'h08; arvalid = 1'b1;
    for (int n = 0; n < 50 && !arready; n++) tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check("r_stall", 64'({rvalid, rresp, rdata}), {30'd0, 1'b1, 2'b00, 32'h0000CAFE});
      check("r_stall_noaccept", 64'(arready), 64'd0);
      tick();
    end
    arvalid = 1'b0; rready = 1'b1;
    tick();
    check("r_release", 64'(rvalid), 64'd0);

    // Reset pulse in the middle of an outstanding read.
    w(6'h00, 32'h00000101);
    strobe(4'b0001, 48'h000_000_000_777);
    tick();
    rready = 1'b0;
    araddr = 6'h08; arvalid = 1'b1;
    for (int n = 0; n < 50 && !arready; n++) tick();
    tick();
    check("pre_reset_busy", 64'({rvalid, irq}), 64'h3);
    rst_n = 1'b0;
    #1;
    check("reset_mid_read", outs(), 64'd0);
    arvalid = 1'b0; rready = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_resp_after_reset", 64'(rvalid), 64'd0);
    end
    rchk("scratch_reset", 6'h08, 32'h0);
    rchk("ctrl_reset", 6'h00, 32'h0);
    rchk("data0_reset", 6'h10, 32'h0);
    rchk("status_reset", 6'h04, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
